// File: rtl/ddr_display_pkg.sv
// Shared types, constants and double-dabble helpers for the display source scheduler.
// Leading-zero blanking (used when BLANK_LEADING_ZEROS_EN is defined) lives here as blank_leading().
package ddr_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_SHOW
  } sched_state_t;

  localparam int BCD_DIGITS  = 4;
  localparam int SAT_MAX     = 9999;
  localparam int CONV_CYCLES = 14;
  localparam int BIN_W       = 14;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int SR_W        = BCD_W + BIN_W;
  localparam int CNT_W       = $clog2(CONV_CYCLES);
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (t[BIN_W + 4*d +: 4] >= 4'd5)
        t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Digit 0 is never blanked so that a value of zero still shows a single 0.
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = b;
    lead = 1'b1;
    for (int d = BCD_DIGITS - 1; d >= 1; d--) begin
      if (lead && (b[4*d +: 4] == 4'd0))
        r[4*d +: 4] = BLANK_NIBBLE;
      else
        lead = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_source_scheduler_if.sv
// Bus between the display source scheduler and its requesters / seven-segment mux driver.
interface display_source_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int VAL_W   = 14
);
  logic [VAL_W-1:0]         score;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*VAL_W-1:0] req_val;
  logic [NUM_REQ-1:0]       ack;
  logic [15:0]              BCD;
  logic                     busy;
  logic [2:0]               active_src;

  modport master (
    output score, req, req_val,
    input  ack, BCD, busy, active_src
  );

  modport slave (
    input  score, req, req_val,
    output ack, BCD, busy, active_src
  );
endinterface

// File: rtl/display_source_scheduler_bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble, one bit per cycle).
module bin2bcd_seq
  import ddr_display_pkg::*;
(
  input  logic             displayClk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] result
);

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] cnt;
  logic             running;

  assign sr_next = dd_step(sr);
  // done and result describe the final shift happening on this edge, so the caller
  // can register the finished value without an extra cycle.
  assign done    = running && (cnt == CNT_W'(CONV_CYCLES - 1));
  assign result  = sr_next[SR_W-1 -: BCD_W];

  always_ff @(posedge displayClk) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      sr      <= {{BCD_W{1'b0}}, bin};
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      sr  <= sr_next;
      cnt <= cnt + CNT_W'(1);
      if (done)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Chooses score or a pre-empting event value for the 4-digit display and converts it to BCD.
// Define BLANK_LEADING_ZEROS_EN to replace leading zero digits (3..1) with the blank nibble 4'hF.
module display_source_scheduler
  import ddr_display_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int VAL_W      = 14,
  parameter int HOLD_TICKS = 1000
)(
  input logic                       displayClk,
  input logic                       rst,
  display_source_scheduler_if.slave bus
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SRC_W  = 3;
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [SRC_W-1:0] SRC_SCORE = SRC_W'(NUM_REQ);

  sched_state_t       state;
  logic [NUM_REQ-1:0] pend;
  logic [VAL_W-1:0]   val_r [NUM_REQ];
  logic [VAL_W-1:0]   sel_val;
  logic [SRC_W-1:0]   src;
  logic [VAL_W-1:0]   last_score;
  logic               bg_dirty;
  logic [HOLD_W-1:0]  hold;
  logic [NUM_REQ-1:0] ack_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [SRC_W-1:0]   active_r;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               preempt;
  logic               take;
  logic [BIN_W-1:0]   sel_sat;
  logic               conv_start;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_result;
  logic [BCD_W-1:0]   bcd_fmt;

  // NOTE: every always_comb output gets a default before the loop; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        pick_any = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  assign preempt    = pick_any && (SRC_W'(pick_idx) < active_r);
  assign take       = ((state == ST_IDLE) && pick_any) || ((state == ST_SHOW) && preempt);
  assign sel_sat    = (sel_val > VAL_W'(SAT_MAX)) ? BIN_W'(SAT_MAX) : sel_val[BIN_W-1:0];
  assign conv_start = (state == ST_LOAD);

`ifdef BLANK_LEADING_ZEROS_EN
  assign bcd_fmt = blank_leading(conv_result);
`else
  assign bcd_fmt = conv_result;
`endif

  bin2bcd_seq u_bin2bcd (
    .displayClk (displayClk),
    .rst        (rst),
    .start      (conv_start),
    .bin        (sel_sat),
    .done       (conv_done),
    .result     (conv_result)
  );

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below reads the values from before this edge regardless of statement order.
  always_ff @(posedge displayClk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pend       <= '0;
      for (int i = 0; i < NUM_REQ; i++) val_r[i] <= '0;
      sel_val    <= '0;
      src        <= SRC_SCORE;
      last_score <= '0;
      bg_dirty   <= 1'b1;
      hold       <= '0;
      ack_r      <= '0;
      bcd_r      <= '0;
      active_r   <= SRC_SCORE;
    end else begin
      ack_r <= '0;

      // A new strobe beats a simultaneous take: the request stays pending with its new value.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i]) begin
          pend[i]  <= 1'b1;
          val_r[i] <= bus.req_val[i*VAL_W +: VAL_W];
        end else if (take && (pick_idx == IDX_W'(i))) begin
          pend[i] <= 1'b0;
        end
      end

      if (take) begin
        ack_r[pick_idx] <= 1'b1;
        src             <= SRC_W'(pick_idx);
        sel_val         <= val_r[pick_idx];
        state           <= ST_LOAD;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (bg_dirty || (bus.score != last_score)) begin
              src        <= SRC_SCORE;
              sel_val    <= bus.score;
              last_score <= bus.score;
              bg_dirty   <= 1'b0;
              state      <= ST_LOAD;
            end
          end
          ST_LOAD: state <= ST_CONV;
          ST_CONV: begin
            if (conv_done) begin
              bcd_r    <= bcd_fmt;
              active_r <= src;
              if (src == SRC_SCORE) begin
                state <= ST_IDLE;
              end else begin
                hold  <= HOLD_W'(HOLD_TICKS - 1);
                state <= ST_SHOW;
              end
            end
          end
          ST_SHOW: begin
            if (hold == '0) begin
              bg_dirty <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              hold <= hold - HOLD_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ack        = ack_r;
  assign bus.BCD        = bcd_r;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.active_src = active_r;

endmodule
